// File: rtl/imem_loader.sv
// Streams a word count and big-endian instruction words from a byte channel into instruction memory,
// holding the CPU in reset until the load finishes. Trailing checksum byte checked only with LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [7:0]  RX_Data,
    input  logic        RX_Valid,
    output logic        RX_Ready,
    output logic [31:0] W_Addr,
    output logic [31:0] W_Ins,
    output logic        WE,
    output logic        CPU_RST,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CHK,
        FIN,
        FAIL
    } state_t;

    localparam logic [31:0] LP_MAX_WORDS = 32'(MAX_WORDS);

    // State reached once the last word is written (or immediately for an empty image).
`ifdef LOADER_CHECKSUM_EN
    localparam state_t LP_END_STATE = CHK;
`else
    localparam state_t LP_END_STATE = FIN;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_lenHi;
    logic [15:0] r_remain;
    logic [1:0]  r_byteCnt;
    logic [31:0] r_word;
    logic [31:0] r_addr;
    logic [15:0] w_count;
    logic        w_tooLong;
    logic        w_lastWord;
    logic        w_restart;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    assign w_count    = {r_lenHi, RX_Data};
    assign w_tooLong  = {16'h0, w_count} > LP_MAX_WORDS;
    assign w_lastWord = (r_remain == 16'd1);
    assign w_restart  = START && (r_state == IDLE || r_state == FIN || r_state == FAIL);

    assign W_Addr = r_addr;
    assign W_Ins  = r_word;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        RX_Ready = 1'b0;
        WE       = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        ERR      = 1'b0;
        CPU_RST  = 1'b1;
        case (r_state)
            IDLE: begin
                if (START) w_next = LEN_HI;
            end
            LEN_HI: begin
                RX_Ready = 1'b1;
                BUSY     = 1'b1;
                if (RX_Valid) w_next = LEN_LO;
            end
            LEN_LO: begin
                RX_Ready = 1'b1;
                BUSY     = 1'b1;
                if (RX_Valid) begin
                    if (w_tooLong) begin
                        w_next = FAIL;
                    end else if (w_count == 16'd0) begin
                        w_next = LP_END_STATE;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                RX_Ready = 1'b1;
                BUSY     = 1'b1;
                if (RX_Valid && r_byteCnt == 2'd3) w_next = WRITE;
            end
            WRITE: begin
                WE     = 1'b1;
                BUSY   = 1'b1;
                w_next = w_lastWord ? LP_END_STATE : DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                RX_Ready = 1'b1;
                BUSY     = 1'b1;
                if (RX_Valid) w_next = (RX_Data == r_csum) ? FIN : FAIL;
            end
`endif
            FIN: begin
                DONE    = 1'b1;
                CPU_RST = 1'b0;
                if (START) w_next = LEN_HI;
            end
            FAIL: begin
                ERR = 1'b1;
                if (START) w_next = LEN_HI;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Address advances only after the WRITE cycle so W_Addr is stable while WE is high.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_lenHi   <= 8'h0;
            r_remain  <= 16'h0;
            r_byteCnt <= 2'd0;
            r_word    <= 32'h0;
            r_addr    <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            r_csum    <= 8'h0;
`endif
        end else if (w_restart) begin
            r_lenHi   <= 8'h0;
            r_remain  <= 16'h0;
            r_byteCnt <= 2'd0;
            r_word    <= 32'h0;
            r_addr    <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            r_csum    <= 8'h0;
`endif
        end else begin
            case (r_state)
                LEN_HI: begin
                    if (RX_Valid) r_lenHi <= RX_Data;
                end
                LEN_LO: begin
                    if (RX_Valid) r_remain <= w_count;
                end
                DATA: begin
                    if (RX_Valid) begin
                        r_word    <= {r_word[23:0], RX_Data};
                        r_byteCnt <= r_byteCnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_csum    <= r_csum ^ RX_Data;
`endif
                    end
                end
                WRITE: begin
                    r_addr   <= r_addr + 32'd4;
                    r_remain <= r_remain - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected memory writes and final status come from a queue-based model.
// Works in both builds; checksum sequences are exercised only when LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0;
    localparam int          MAXW = 256;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  RX_Data = 8'h0;
    logic        RX_Valid = 1'b0;
    logic        RX_Ready;
    logic [31:0] W_Addr;
    logic [31:0] W_Ins;
    logic        WE;
    logic        CPU_RST;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .RX_Data(RX_Data), .RX_Valid(RX_Valid), .RX_Ready(RX_Ready),
        .W_Addr(W_Addr), .W_Ins(W_Ins), .WE(WE),
        .CPU_RST(CPU_RST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        expQ[$];
    logic [7:0] payload[$];
    int         nChecks = 0;
    int         nPass = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Every write strobe must match the oldest outstanding expected write; status rules hold every cycle.
    always @(negedge CLK) begin
        wr_t e;
        if (RST) begin
            if (WE) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL unexpected_we: write %h <= %h, no write expected", W_Addr, W_Ins);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("write_addr", W_Addr, e.addr);
                    checkOutput("write_data", W_Ins, e.data);
                end
                checkOutput("ready_in_write", RX_Ready, 0);
            end
            checkOutput("cpu_rst_vs_done", CPU_RST, !DONE);
            checkOutput("busy_exclusive", BUSY && (DONE || ERR), 0);
            checkOutput("ready_implies_busy", RX_Ready && !BUSY, 0);
        end
    end

    function automatic int pickGap(input int g);
        return (g < 0) ? int'($urandom_range(0, 3)) : g;
    endfunction

    task automatic sendByte(input logic [7:0] b, input int gap);
        bit acc;
        acc = 1'b0;
        RX_Valid = 1'b0;
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
        RX_Valid = 1'b1;
        RX_Data  = b;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge CLK);
            acc = RX_Ready;
            @(posedge CLK);
            #1;
        end
        RX_Valid = 1'b0;
        RX_Data  = 8'($urandom);
        if (!acc) begin
            nChecks++;
            $display("[TB] FAIL rx_handshake: byte %h not accepted, required acceptance within 200 cycles", b);
        end
    endtask

    task automatic startLoad();
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        checkOutput("start_busy", BUSY, 1);
        checkOutput("start_done_low", DONE, 0);
        checkOutput("start_err_low", ERR, 0);
        checkOutput("start_cpu_rst", CPU_RST, 1);
        checkOutput("start_ready", RX_Ready, 1);
        @(posedge CLK);
        #1;
    endtask

    task automatic fillPayload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
    endtask

    task automatic applyStimulus(input int count, input int gap, input bit literalExp,
                                 input bit badCsum, input int injectWord);
        logic [7:0]  cs;
        logic [15:0] c16;
        bit          expDone;
        wr_t         e;
        cs  = 8'h0;
        c16 = 16'(count);
        startLoad();
        sendByte(c16[15:8], pickGap(gap));
        sendByte(c16[7:0], pickGap(gap));
        if (count > MAXW) begin
            @(negedge CLK);
            checkOutput("len_err", ERR, 1);
            checkOutput("len_done", DONE, 0);
            checkOutput("len_cpu_rst", CPU_RST, 1);
            checkOutput("len_busy", BUSY, 0);
            checkOutput("len_no_writes", expQ.size(), 0);
            @(posedge CLK);
            #1;
            return;
        end
        for (int w = 0; w < count; w++) begin
            if (!literalExp) begin
                e.addr = BASE + 32'(4 * w);
                e.data = {payload[4*w], payload[4*w+1], payload[4*w+2], payload[4*w+3]};
                expQ.push_back(e);
            end
            for (int k = 0; k < 4; k++) begin
                sendByte(payload[4*w+k], pickGap(gap));
                cs = cs ^ payload[4*w+k];
                if (w == injectWord && k == 1) begin
                    START = 1'b1;
                    @(posedge CLK);
                    #1;
                    START = 1'b0;
                end
            end
        end
`ifdef LOADER_CHECKSUM_EN
        expDone = !badCsum;
        sendByte(badCsum ? (cs ^ 8'h01) : cs, pickGap(gap));
        @(negedge CLK);
`else
        expDone = 1'b1;
        if (count > 0) begin
            @(negedge CLK);
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
`endif
        checkOutput("final_done", DONE, expDone);
        checkOutput("final_err", ERR, !expDone);
        checkOutput("final_cpu_rst", CPU_RST, !expDone);
        checkOutput("final_busy", BUSY, 0);
        checkOutput("writes_drained", expQ.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wr_t e;
        int  cnt;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        checkOutput("reset_ready", RX_Ready, 0);
        checkOutput("reset_we", WE, 0);
        checkOutput("reset_ins", W_Ins, 32'h0);
        checkOutput("reset_addr", W_Addr, BASE);
        checkOutput("reset_cpu_rst", CPU_RST, 1);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_done", DONE, 0);
        checkOutput("reset_err", ERR, 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        $display("[TB] two-word reference image");
        payload = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
        e.addr = 32'h0000_0000; e.data = 32'h2008_0005; expQ.push_back(e);
        e.addr = 32'h0000_0004; e.data = 32'h0000_0008; expQ.push_back(e);
        applyStimulus(2, 0, 1'b1, 1'b0, -1);

        RX_Valid = 1'b1;
        RX_Data  = 8'hFF;
        repeat (3) @(posedge CLK);
        #1;
        RX_Valid = 1'b0;
        @(negedge CLK);
        checkOutput("fin_hold_done", DONE, 1);
        checkOutput("fin_hold_ready", RX_Ready, 0);
        @(posedge CLK);
        #1;

        $display("[TB] same image with 3-cycle stalls, restarted from FIN");
        e.addr = 32'h0000_0000; e.data = 32'h2008_0005; expQ.push_back(e);
        e.addr = 32'h0000_0004; e.data = 32'h0000_0008; expQ.push_back(e);
        applyStimulus(2, 3, 1'b1, 1'b0, -1);

        $display("[TB] oversize counts");
        applyStimulus(32'h0101, 0, 1'b0, 1'b0, -1);
        applyStimulus(int'($urandom_range(258, 65535)), -1, 1'b0, 1'b0, -1);

`ifdef LOADER_CHECKSUM_EN
        $display("[TB] checksum pass and fail");
        payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        e.addr = BASE; e.data = 32'hAABB_CCDD; expQ.push_back(e);
        applyStimulus(1, 0, 1'b1, 1'b0, -1);
        e.addr = BASE; e.data = 32'hAABB_CCDD; expQ.push_back(e);
        applyStimulus(1, 0, 1'b1, 1'b1, -1);
`endif

        $display("[TB] START pulsed during DATA");
        fillPayload(12);
        applyStimulus(3, -1, 1'b0, 1'b0, 1);

        $display("[TB] empty image");
        applyStimulus(0, -1, 1'b0, 1'b0, -1);

        $display("[TB] reset after two of four words");
        fillPayload(16);
        startLoad();
        sendByte(8'h00, 0);
        sendByte(8'h04, 0);
        for (int w = 0; w < 2; w++) begin
            e.addr = BASE + 32'(4 * w);
            e.data = {payload[4*w], payload[4*w+1], payload[4*w+2], payload[4*w+3]};
            expQ.push_back(e);
            for (int k = 0; k < 4; k++) sendByte(payload[4*w+k], pickGap(-1));
        end
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("abort_busy", BUSY, 0);
        checkOutput("abort_cpu_rst", CPU_RST, 1);
        checkOutput("abort_we", WE, 0);
        checkOutput("abort_addr", W_Addr, BASE);
        checkOutput("abort_ready", RX_Ready, 0);
        checkOutput("abort_writes", expQ.size(), 0);
        @(posedge CLK);
        #1;
        fillPayload(4);
        applyStimulus(1, -1, 1'b0, 1'b0, -1);

        $display("[TB] count boundaries");
        applyStimulus(257, 0, 1'b0, 1'b0, -1);
        fillPayload(4 * MAXW);
        applyStimulus(MAXW, 0, 1'b0, 1'b0, -1);

        $display("[TB] random loads");
        for (int i = 0; i < 15; i++) begin
            cnt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(257, 2000)) : int'($urandom_range(0, 8));
            fillPayload(4 * 8);
            applyStimulus(cnt, -1, 1'b0, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0, byte address of the first instruction word written.
REQ-002 SHALL have parameter MAX_WORDS, default 256, largest accepted word count.
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-low reset.
REQ-005 SHALL have port START  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port RX_Data  input  8  incoming stream byte.
REQ-007 SHALL have port RX_Valid  input  1  RX_Data is valid this cycle.
REQ-008 SHALL have port RX_Ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port W_Addr  output  32  instruction memory byte address.
REQ-010 SHALL have port W_Ins  output  32  instruction word to write.
REQ-011 SHALL have port WE  output  1  write strobe to instruction memory, one cycle per word.
REQ-012 SHALL have port CPU_RST  output  1  active-high reset for the fetch stage and CPU.
REQ-013 SHALL have ports BUSY, DONE, ERR  output  1 each  load in progress / completed / failed.

Function
REQ-014 SHALL use states IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, FIN, FAIL.
REQ-015 SHALL transfer a byte only in a cycle with RX_Valid=1 and RX_Ready=1.
REQ-016 SHALL drive RX_Ready=1 only in LEN_HI, LEN_LO, DATA, CHK.
REQ-017 SHALL leave IDLE, FIN or FAIL for LEN_HI on START=1; START in any other state is ignored.
REQ-018 SHALL read a 16-bit word count, high byte in LEN_HI, low byte in LEN_LO.
REQ-019 SHALL go to FAIL from LEN_LO when count > MAX_WORDS, with no write issued.
REQ-020 SHALL go from LEN_LO with count=0 directly to CHK (macro on) or FIN (macro off).
REQ-021 SHALL assemble each word from 4 DATA bytes, big-endian, first byte to W_Ins[31:24].
REQ-022 SHALL enter WRITE the cycle after the 4th byte; WRITE lasts exactly one cycle with WE=1 and W_Ins, W_Addr stable.
REQ-023 SHALL set W_Addr=BASE_ADDR for the first word and add 4 after each WRITE, wrapping modulo 2^32.
REQ-024 SHALL go from WRITE to DATA while words remain, else to CHK (macro on) or FIN (macro off).
REQ-025 SHALL drive WE=0 in all states except WRITE.
REQ-026 SHALL drive BUSY=1 in LEN_HI, LEN_LO, DATA, WRITE, CHK; DONE=1 only in FIN; ERR=1 only in FAIL.
REQ-027 SHALL drive CPU_RST=0 only in FIN, so the CPU is released the cycle DONE rises.
REQ-028 SHALL hold state and partial word unchanged while RX_Valid=0 (arbitrary stall length).

Reset
REQ-029 SHALL, with RST=0 at a rising edge, enter IDLE and set RX_Ready=0, WE=0, W_Ins=0, W_Addr=BASE_ADDR, CPU_RST=1, BUSY=0, DONE=0, ERR=0, counters and checksum cleared.
REQ-030 SHALL abort any load on mid-operation reset; words already written remain in memory, no further WE issued.

Configuration
REQ-031 SHALL compile checksum checking only when LOADER_CHECKSUM_EN is defined.
REQ-032 With LOADER_CHECKSUM_EN: one trailing byte accepted in CHK; XOR of all DATA bytes equal to it -> FIN, else -> FAIL.
REQ-033 Without LOADER_CHECKSUM_EN: no CHK state logic, no trailing byte consumed, last WRITE -> FIN.

Verification
REQ-034 Count 2, bytes 20 08 00 05 / 00 00 00 08 -> WE pulses: 0x00000000<=0x20080005, 0x00000004<=0x00000008; then DONE=1, CPU_RST=0.
REQ-035 Same stream with RX_Valid deasserted 3 cycles between every byte -> identical writes, no extra WE.
REQ-036 Count 0x0101 with MAX_WORDS=256 -> FAIL, ERR=1, CPU_RST=1, zero WE pulses.
REQ-037 Macro on, 1 word AA BB CC DD, checksum 0x00 -> DONE; checksum 0x01 -> ERR (word still written once).
REQ-038 RST=0 after 2 of 4 words -> IDLE, CPU_RST=1; new START + count 1 writes at BASE_ADDR again.
REQ-039 START pulsed during DATA -> ignored; START in FIN -> new load, DONE falls, CPU_RST rises next cycle.
